// File: rtl/ryuki_datatypes.sv
// Ryuki tracer record layout and the constants/state type shared by the
// trace record serialiser.
package ryuki_datatypes;

  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
  } trace_window_t;

  typedef struct packed {
    logic [31:0]   time_start;
    logic [31:0]   time_end;
    trace_window_t mem_access_req;
    trace_window_t mem_access_res;
  } trace_if_t;

  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
    logic [31:0] time_idle_start;
    logic [31:0] time_idle_end;
  } trace_id_t;

  typedef struct packed {
    logic [31:0]   time_start;
    logic [31:0]   time_end;
    trace_window_t mem_access_req;
  } trace_ex_t;

  typedef struct packed {
    logic [31:0]   time_start;
    logic [31:0]   time_end;
    trace_window_t mem_access_res;
  } trace_wb_t;

  // One completed instruction record from the tracer (641 bits).
  typedef struct packed {
    logic        pass_through;
    logic [31:0] instruction;
    logic [31:0] addr;
    trace_if_t   if_data;
    trace_id_t   id_data;
    trace_ex_t   ex_data;
    trace_wb_t   wb_data;
  } trace_output;

  localparam logic [7:0] TRACE_HDR_MAGIC  = 8'hA5;
  localparam int         TRACE_WORDS_FULL = 21;
  localparam int         TRACE_WORDS_PT   = 3;
  localparam int         TRACE_REC_W      = $bits(trace_output);

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

  // Number of 32-bit words a record occupies on the word stream.
  function automatic logic [7:0] trace_word_count(input logic pass_through);
    return pass_through ? 8'(TRACE_WORDS_PT) : 8'(TRACE_WORDS_FULL);
  endfunction

endpackage

// File: rtl/trace_record_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are exact. A push while full or a pop while empty is ignored.
module trace_record_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  // Storage write; contents need no reset since empty gates all reads.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  // Read/write pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/trace_record_serialiser.sv
// Buffers tracer records in a small FIFO and emits each one as a header
// plus payload on a 32-bit valid/ready word stream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The word side holds word_o/word_last_o/word_valid_o stable while
// word_ready_i is low. rec_ready_o depends only on FIFO fullness (or is
// constant 1 in drop mode), never on rec_valid_i.
module trace_record_serialiser
  import ryuki_datatypes::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_valid_i,
  output logic        rec_ready_o,
  input  trace_output rec_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic        word_last_o,
  output logic [7:0]  seq_o,
  output logic [15:0] dropped_o,
  output logic        busy_o
);

  ser_state_t  state;
  ser_state_t  state_next;
  logic [4:0]  idx;
  logic [4:0]  idx_next;
  logic [7:0]  seq;
  logic [15:0] dropped;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        is_last;
  logic [7:0]  count;
  trace_output head;
  logic [31:0] words [TRACE_WORDS_FULL];

  // Full is judged before any same-cycle pop, so a full FIFO never accepts.
  assign rec_ready_o = DROP_ON_FULL ? 1'b1 : !fifo_full;
  assign push        = rec_valid_i && rec_ready_o && !fifo_full;
  assign count       = trace_word_count(head.pass_through);
  assign is_last     = ({3'd0, idx} == (count - 8'd1));
  assign pop         = (state == SER_SEND) && word_ready_i && is_last;

  trace_record_fifo #(
    .WIDTH(TRACE_REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(rec_i),
    .full (fifo_full),
    .empty(fifo_empty),
    .rdata(head)
  );

  // Word layout of the record at the FIFO head; it stays at the head until
  // its last word is accepted, so no separate holding register is needed.
  always_comb begin
    words[0]  = {TRACE_HDR_MAGIC, seq, count, 7'd0, head.pass_through};
    words[1]  = head.instruction;
    words[2]  = head.addr;
    words[3]  = head.if_data.time_start;
    words[4]  = head.if_data.time_end;
    words[5]  = head.if_data.mem_access_req.time_start;
    words[6]  = head.if_data.mem_access_req.time_end;
    words[7]  = head.if_data.mem_access_res.time_start;
    words[8]  = head.if_data.mem_access_res.time_end;
    words[9]  = head.id_data.time_start;
    words[10] = head.id_data.time_end;
    words[11] = head.id_data.time_idle_start;
    words[12] = head.id_data.time_idle_end;
    words[13] = head.ex_data.time_start;
    words[14] = head.ex_data.time_end;
    words[15] = head.ex_data.mem_access_req.time_start;
    words[16] = head.ex_data.mem_access_req.time_end;
    words[17] = head.wb_data.time_start;
    words[18] = head.wb_data.time_end;
    words[19] = head.wb_data.mem_access_res.time_start;
    words[20] = head.wb_data.mem_access_res.time_end;
  end

  // Next-state, word index and word-stream outputs.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    word_valid_o = 1'b0;
    word_o       = 32'd0;
    word_last_o  = 1'b0;
    case (state)
      SER_IDLE: begin
        if (!fifo_empty) begin
          state_next = SER_SEND;
          idx_next   = 5'd0;
        end
      end
      SER_SEND: begin
        word_valid_o = 1'b1;
        word_o       = words[idx];
        word_last_o  = is_last;
        if (word_ready_i) begin
          if (is_last) begin
            state_next = SER_IDLE;
            idx_next   = 5'd0;
          end else begin
            idx_next = idx + 5'd1;
          end
        end
      end
      default: begin
        state_next = SER_IDLE;
        idx_next   = 5'd0;
      end
    endcase
  end

  // State, index, sequence and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SER_IDLE;
      idx     <= 5'd0;
      seq     <= 8'd0;
      dropped <= 16'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (pop) begin
        seq <= seq + 8'd1;
      end
      if (DROP_ON_FULL && rec_valid_i && fifo_full && (dropped != 16'hFFFF)) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

  assign seq_o     = seq;
  assign dropped_o = dropped;
  assign busy_o    = !fifo_empty || (state != SER_IDLE);

endmodule

// File: tb/tb_trace_record_serialiser.sv
// Bench for trace_record_serialiser: a word-queue model of the record
// format, a per-cycle compare process, directed and random stimulus.
module tb_trace_record_serialiser;
  import ryuki_datatypes::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (backpressure mode) ----------------
  logic        rec_valid = 1'b0;
  logic        rec_ready;
  trace_output rec = '0;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [31:0] word;
  logic        word_last;
  logic [7:0]  seq;
  logic [15:0] dropped;
  logic        busy;

  trace_record_serialiser #(.FIFO_DEPTH(4), .DROP_ON_FULL(1'b0)) dut (
    .clk(clk), .rst(rst), .rec_valid_i(rec_valid), .rec_ready_o(rec_ready),
    .rec_i(rec), .word_valid_o(word_valid), .word_ready_i(word_ready),
    .word_o(word), .word_last_o(word_last), .seq_o(seq),
    .dropped_o(dropped), .busy_o(busy)
  );

  // ---------------- DUT (drop mode) ----------------
  logic        d_rec_valid = 1'b0;
  logic        d_rec_ready;
  trace_output d_rec = '0;
  logic        d_word_valid;
  logic        d_word_ready = 1'b0;
  logic [31:0] d_word;
  logic        d_word_last;
  logic [7:0]  d_seq;
  logic [15:0] d_dropped;
  logic        d_busy;

  trace_record_serialiser #(.FIFO_DEPTH(4), .DROP_ON_FULL(1'b1)) dut_drop (
    .clk(clk), .rst(rst), .rec_valid_i(d_rec_valid), .rec_ready_o(d_rec_ready),
    .rec_i(d_rec), .word_valid_o(d_word_valid), .word_ready_i(d_word_ready),
    .word_o(d_word), .word_last_o(d_word_last), .seq_o(d_seq),
    .dropped_o(d_dropped), .busy_o(d_busy)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or no expectation (t=%0t)", name, $time);
  endtask

  // Stimulus record: timestamps in stream order, mapped onto the struct.
  logic [31:0] cur_ts [18];

  function automatic trace_output mk_rec(input logic pt, input logic [31:0] instr,
                                         input logic [31:0] addr, input logic [31:0] ts [18]);
    trace_output r;
    r = '0;
    r.pass_through = pt;
    r.instruction  = instr;
    r.addr         = addr;
    r.if_data.time_start                = ts[0];
    r.if_data.time_end                  = ts[1];
    r.if_data.mem_access_req.time_start = ts[2];
    r.if_data.mem_access_req.time_end   = ts[3];
    r.if_data.mem_access_res.time_start = ts[4];
    r.if_data.mem_access_res.time_end   = ts[5];
    r.id_data.time_start                = ts[6];
    r.id_data.time_end                  = ts[7];
    r.id_data.time_idle_start           = ts[8];
    r.id_data.time_idle_end             = ts[9];
    r.ex_data.time_start                = ts[10];
    r.ex_data.time_end                  = ts[11];
    r.ex_data.mem_access_req.time_start = ts[12];
    r.ex_data.mem_access_req.time_end   = ts[13];
    r.wb_data.time_start                = ts[14];
    r.wb_data.time_end                  = ts[15];
    r.wb_data.mem_access_res.time_start = ts[16];
    r.wb_data.mem_access_res.time_end   = ts[17];
    return r;
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic [7:0]  exp_seq_q[$];
  logic [7:0]  m_seq = 8'd0;

  logic [31:0] got_q[$];
  logic        got_last_q[$];
  int          got_cyc_q[$];
  int          acc_cyc_q[$];
  int          cyc = 0;
  int          n_hs = 0;
  int          n_last_hs = 0;
  logic        prev_stall = 1'b0;
  logic        prev_was_last = 1'b0;
  logic [31:0] prev_word = '0;
  logic        prev_last = 1'b0;

  // A record becomes a header word plus its payload words, in order.
  function automatic void model_push(input logic pt, input logic [31:0] instr, input logic [31:0] addr);
    logic [31:0] w[$];
    int n;
    n = pt ? 3 : 21;
    w.push_back({8'hA5, m_seq, 8'(n), 7'd0, pt});
    w.push_back(instr);
    w.push_back(addr);
    if (!pt) begin
      for (int i = 0; i < 18; i++) w.push_back(cur_ts[i]);
    end
    for (int i = 0; i < w.size(); i++) begin
      exp_q.push_back(w[i]);
      exp_last_q.push_back(i == w.size() - 1);
      exp_seq_q.push_back(m_seq);
    end
    m_seq = m_seq + 8'd1;
  endfunction

  // Compare process: sample midway between active edges.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      exp_seq_q.delete();
      m_seq         = 8'd0;
      prev_stall    = 1'b0;
      prev_was_last = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, word_valid}, 32'd1);
        check("hold_word", word, prev_word);
        check("hold_last", {31'd0, word_last}, {31'd0, prev_last});
      end
      if (prev_was_last) check("bubble_after_last", {31'd0, word_valid}, 32'd0);
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          fail_note("unexpected_word");
        end else begin
          check("word", word, exp_q.pop_front());
          check("word_last", {31'd0, word_last}, {31'd0, exp_last_q.pop_front()});
          check("seq", {24'd0, seq}, {24'd0, exp_seq_q.pop_front()});
        end
        got_q.push_back(word);
        got_last_q.push_back(word_last);
        got_cyc_q.push_back(cyc);
        n_hs++;
        if (word_last) n_last_hs++;
      end
      prev_stall    = word_valid && !word_ready;
      prev_was_last = word_valid && word_ready && word_last;
      prev_word     = word;
      prev_last     = word_last;
      if (rec_valid && rec_ready) begin
        model_push(rec.pass_through, rec.instruction, rec.addr);
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // Drop-mode DUT: collect the addr word of each emitted record.
  logic [31:0] d_addr_q[$];
  int          d_idx = 0;
  always @(negedge clk) begin
    if (rst) begin
      d_idx = 0;
    end else if (d_word_valid && d_word_ready) begin
      if (d_idx == 2) d_addr_q.push_back(d_word);
      d_idx = d_word_last ? 0 : d_idx + 1;
    end
  end

  // ---------------- driver tasks ----------------
  // Present a record and hold it until accepted; called at posedge+1.
  task automatic send_rec(input logic pt, input logic [31:0] instr, input logic [31:0] addr,
                          output int last_at_acc);
    bit done;
    done = 0;
    last_at_acc = -1;
    rec = mk_rec(pt, instr, addr, cur_ts);
    rec_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (rec_ready) begin
        done = 1;
        #1 last_at_acc = n_last_hs;
      end
      @(posedge clk);
      #1;
    end
    rec_valid = 1'b0;
    if (!done) fail_note("rec_accept_timeout");
  endtask

  task automatic rand_ts();
    for (int i = 0; i < 18; i++) cur_ts[i] = $urandom;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) fail_note("drain_timeout");
  endtask

  task automatic do_reset();
    rec_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int  base, a0, hs0, dummy, snap;
  bit  taken, found;
  logic [3:0] bp_pat;

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check("rst_word", word, 32'd0);
    check("rst_word_last", {31'd0, word_last}, 32'd0);
    check("rst_seq", {24'd0, seq}, 32'd0);
    check("rst_dropped", {16'd0, dropped}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rec_ready", {31'd0, rec_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single full record, then a pass-through record directly behind it.
    word_ready = 1'b1;
    base = got_q.size();
    a0 = acc_cyc_q.size();
    for (int i = 0; i < 18; i++) cur_ts[i] = 32'(i + 1);
    send_rec(1'b0, 32'h00A00093, 32'h80, dummy);
    rand_ts();
    send_rec(1'b1, $urandom, $urandom, dummy);
    wait_idle();
    if (got_q.size() < base + 24) begin
      fail_note("first_two_records_short");
    end else begin
      check("t1_hdr", got_q[base], 32'hA5001500);
      check("t1_instr", got_q[base+1], 32'h00A00093);
      check("t1_addr", got_q[base+2], 32'h00000080);
      for (int i = 0; i < 18; i++) check("t1_ts", got_q[base+3+i], 32'(i + 1));
      for (int i = 0; i < 21; i++) check("t1_last", {31'd0, got_last_q[base+i]}, (i == 20) ? 32'd1 : 32'd0);
      check("t1_latency", 32'(got_cyc_q[base] - acc_cyc_q[a0]), 32'd2);
      check("t2_hdr", got_q[base+21], 32'hA5010301);
      check("t2_last_mid", {31'd0, got_last_q[base+22]}, 32'd0);
      check("t2_last_end", {31'd0, got_last_q[base+23]}, 32'd1);
      check("t2_bubble", 32'(got_cyc_q[base+21] - got_cyc_q[base+20]), 32'd2);
    end

    // Backpressure with ready pattern 1-0-0-1.
    hs0 = n_hs;
    bp_pat = 4'b1001;
    rand_ts();
    send_rec(1'b0, $urandom, $urandom, dummy);
    for (int k = 0; k < 120 && busy; k++) begin
      word_ready = bp_pat[k % 4];
      @(posedge clk);
      #1;
    end
    word_ready = 1'b1;
    wait_idle();
    check("bp_handshakes", 32'(n_hs - hs0), 32'd21);

    // FIFO full with backpressure: 4 accepted, 5th waits for a drain.
    word_ready = 1'b0;
    hs0 = n_last_hs;
    for (int k = 0; k < 4; k++) begin
      rand_ts();
      send_rec(1'b0, $urandom, $urandom, dummy);
    end
    rand_ts();
    rec = mk_rec(1'b0, $urandom, $urandom, cur_ts);
    rec_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_rec_ready", {31'd0, rec_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    word_ready = 1'b1;
    send_rec(rec.pass_through, rec.instruction, rec.addr, snap);
    check("full_accept_after_drain", 32'(snap - hs0), 32'd1);
    wait_idle();

    // Drop mode: 5th record into a full FIFO is discarded.
    d_word_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 18; i++) cur_ts[i] = 32'd0;
      d_rec = mk_rec(1'b1, 32'(k), 32'(k), cur_ts);
      d_rec_valid = 1'b1;
      @(negedge clk);
      check("drop_rec_ready", {31'd0, d_rec_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    d_rec_valid = 1'b0;
    @(negedge clk);
    check("drop_count", {16'd0, d_dropped}, 32'd1);
    @(posedge clk);
    #1 d_word_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("drop_records_out", d_addr_q.size(), 32'd4);
    for (int k = 0; k < 4 && k < d_addr_q.size(); k++) check("drop_order", d_addr_q[k], 32'(k));

    // Randomised traffic with random sink stalls.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      taken = rec_valid && rec_ready;
      @(posedge clk);
      #1;
      word_ready = ($urandom_range(0, 3) != 0);
      if (!rec_valid || taken) begin
        rec_valid = ($urandom_range(0, 2) == 0);
        if (rec_valid) begin
          rand_ts();
          rec = mk_rec(1'($urandom_range(0, 1)), $urandom, $urandom, cur_ts);
        end
      end
    end
    rec_valid = 1'b0;
    word_ready = 1'b1;
    wait_idle();

    // Sequence wrap over 257 pass-through records.
    do_reset();
    base = got_q.size();
    for (int k = 0; k < 257; k++) begin
      rand_ts();
      send_rec(1'b1, $urandom, $urandom, dummy);
    end
    wait_idle();
    if (got_q.size() < base + 3 * 257) begin
      fail_note("wrap_short");
    end else begin
      check("wrap_first", got_q[base], 32'hA5000301);
      check("wrap_255", got_q[base + 3 * 255], 32'hA5FF0301);
      check("wrap_256", got_q[base + 3 * 256], 32'hA5000301);
    end
    check("wrap_dropped", {16'd0, dropped}, 32'd0);

    // Reset in the middle of a full record with two more queued.
    base = got_q.size();
    rand_ts();
    send_rec(1'b0, $urandom, $urandom, dummy);
    send_rec(1'b1, $urandom, $urandom, dummy);
    send_rec(1'b1, $urandom, $urandom, dummy);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      #1;
      if (got_q.size() >= base + 6) found = 1;
      @(posedge clk);
      #1;
    end
    if (!found) fail_note("midrec_wait");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_word_valid", {31'd0, word_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_seq", {24'd0, seq}, 32'd0);
    @(posedge clk);
    #1;
    base = got_q.size();
    rand_ts();
    send_rec(1'b0, $urandom, $urandom, dummy);
    wait_idle();
    if (got_q.size() < base + 21) fail_note("midrst_after_short");
    else check("midrst_next_hdr", got_q[base], 32'hA5001500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
